// File: rtl/aes256_key_sched_ctrl_pkg.sv
// Shared types, widths and GF(2^8) helpers for the
// AES-256 key-schedule sequencer and its expansion step.
package aes256_key_sched_ctrl_pkg;

  localparam int KEY_W = 256;
  localparam int RK_W  = 128;
  localparam int NRK   = 15;

  typedef enum logic [1:0] {
    S_IDLE,
    S_EMIT,
    S_STEP,
    S_WAIT
  } state_t;

  function automatic logic [7:0] rcon_of(
    input logic [2:0] i
  );
    logic [7:0] r;
    r = 8'h00;
    unique case (i)
      3'd0:    r = 8'h01;
      3'd1:    r = 8'h02;
      3'd2:    r = 8'h04;
      3'd3:    r = 8'h08;
      3'd4:    r = 8'h10;
      3'd5:    r = 8'h20;
      3'd6:    r = 8'h40;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  function automatic logic [7:0] gf_mul(
    input logic [7:0] a,
    input logic [7:0] b
  );
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Inverse as a^254 via an addition chain, then the affine map.
  function automatic logic [7:0] sbox(
    input logic [7:0] a
  );
    logic [7:0] x3, x7, x15, x31, x63, x127, v, s;
    x3   = gf_mul(gf_mul(a, a), a);
    x7   = gf_mul(gf_mul(x3, x3), a);
    x15  = gf_mul(gf_mul(x7, x7), a);
    x31  = gf_mul(gf_mul(x15, x15), a);
    x63  = gf_mul(gf_mul(x31, x31), a);
    x127 = gf_mul(gf_mul(x63, x63), a);
    v    = gf_mul(x127, x127);
    s    = '0;
    for (int i = 0; i < 8; i++) begin
      s[i] = v[i] ^ v[(i + 4) % 8] ^ v[(i + 5) % 8]
           ^ v[(i + 6) % 8] ^ v[(i + 7) % 8];
    end
    return s ^ 8'h63;
  endfunction

  function automatic logic [31:0] sub_word(
    input logic [31:0] w
  );
    return {sbox(w[31:24]), sbox(w[23:16]),
            sbox(w[15:8]),  sbox(w[7:0])};
  endfunction

endpackage

// File: rtl/aes256_key_step.sv
// One AES-256 half-step: four new words from an 8-word window,
// through a single S-box word unit and STEP_LAT registered stages.
module aes256_key_step
  import aes256_key_sched_ctrl_pkg::*;
#(
  parameter int STEP_LAT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             step_go,
  input  logic             step_a,
  input  logic [7:0]       rcon,
  input  logic [KEY_W-1:0] window,
  output logic [RK_W-1:0]  new_w,
  output logic             step_vld
);

  logic [31:0] w7, sw_in, t;
  logic [31:0] n0, n1, n2, n3;

  assign w7    = window[31:0];
  assign sw_in = step_a ? {w7[23:0], w7[31:24]} : w7;
  assign t     = sub_word(sw_in)
               ^ (step_a ? {rcon, 24'h0} : 32'h0);
  assign n0    = window[255:224] ^ t;
  assign n1    = window[223:192] ^ n0;
  assign n2    = window[191:160] ^ n1;
  assign n3    = window[159:128] ^ n2;

  logic [RK_W-1:0]     pipe_d [STEP_LAT];
  logic [STEP_LAT-1:0] pipe_v;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pipe_v <= '0;
      for (int i = 0; i < STEP_LAT; i++)
        pipe_d[i] <= '0;
    end else begin
      pipe_v[0] <= step_go;
      if (step_go) pipe_d[0] <= {n0, n1, n2, n3};
      for (int i = 1; i < STEP_LAT; i++) begin
        pipe_v[i] <= pipe_v[i-1];
        pipe_d[i] <= pipe_d[i-1];
      end
    end
  end

  assign new_w    = pipe_d[STEP_LAT-1];
  assign step_vld = pipe_v[STEP_LAT-1];

endmodule

// File: rtl/aes256_key_sched_ctrl.sv
// AES-256 key-schedule sequencer: accepts a key, slides an 8-word
// window through 13 A/B steps, streams rk0..rk14 on valid/ready.
module aes256_key_sched_ctrl
  import aes256_key_sched_ctrl_pkg::*;
#(
  parameter int STEP_LAT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             key_valid,
  output logic             key_ready,
  input  logic [KEY_W-1:0] key,
  output logic             rk_valid,
  input  logic             rk_ready,
  output logic [RK_W-1:0]  rk,
  output logic [3:0]       rk_idx,
  output logic             busy,
  output logic             done
);

  state_t           state, state_n;
  logic [KEY_W-1:0] win, win_n;
  logic [RK_W-1:0]  rk_n;
  logic [3:0]       idx_n;
  logic             rkv_n, busy_n, done_n;
  logic [1:0]       cnt, cnt_n;

  logic             step_go, step_a, step_vld;
  logic [7:0]       rcon;
  logic [2:0]       ridx;
  logic [RK_W-1:0]  new_w;

  // Even targets are type A; rcon index is target/2 - 1.
  assign step_a    = ~rk_idx[0];
  assign ridx      = 3'(rk_idx[3:1] - 3'd1);
  assign rcon      = rcon_of(ridx);
  assign key_ready = (state == S_IDLE);

  aes256_key_step #(
    .STEP_LAT (STEP_LAT)
  ) u_step (
    .clk      (clk),
    .rst      (rst),
    .step_go  (step_go),
    .step_a   (step_a),
    .rcon     (rcon),
    .window   (win),
    .new_w    (new_w),
    .step_vld (step_vld)
  );

  always_comb begin
    state_n = state;
    win_n   = win;
    rk_n    = rk;
    idx_n   = rk_idx;
    rkv_n   = rk_valid;
    busy_n  = busy;
    done_n  = 1'b0;
    cnt_n   = cnt;
    step_go = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (key_valid) begin
          win_n   = key;
          rk_n    = key[255:128];
          idx_n   = 4'd0;
          rkv_n   = 1'b1;
          busy_n  = 1'b1;
          state_n = S_EMIT;
        end
      end
      S_EMIT: begin
        if (rk_ready) begin
          unique case (1'b1)
            (rk_idx == 4'd0): begin
              rk_n  = win[127:0];
              idx_n = 4'd1;
            end
            (rk_idx == 4'(NRK - 1)): begin
              rkv_n   = 1'b0;
              busy_n  = 1'b0;
              done_n  = 1'b1;
              state_n = S_IDLE;
            end
            default: begin
              rkv_n   = 1'b0;
              idx_n   = rk_idx + 4'd1;
              state_n = S_STEP;
            end
          endcase
        end
      end
      S_STEP: begin
        step_go = 1'b1;
        cnt_n   = 2'(STEP_LAT - 1);
        state_n = S_WAIT;
      end
      S_WAIT: begin
        if (cnt != 2'd0) begin
          cnt_n = cnt - 2'd1;
        end else if (step_vld) begin
          win_n   = {win[127:0], new_w};
          rk_n    = new_w;
          rkv_n   = 1'b1;
          state_n = S_EMIT;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      win      <= '0;
      rk       <= '0;
      rk_idx   <= '0;
      rk_valid <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      cnt      <= '0;
    end else begin
      state    <= state_n;
      win      <= win_n;
      rk       <= rk_n;
      rk_idx   <= idx_n;
      rk_valid <= rkv_n;
      busy     <= busy_n;
      done     <= done_n;
      cnt      <= cnt_n;
    end
  end

  // A result ahead of the latency count means the step unit is broken.
  always @(posedge clk) begin
    if (!rst && state == S_WAIT && step_vld)
      assert (cnt == 2'd0);
  end

endmodule
